// File: rtl/ifmap_pkg.sv
// Shared definitions for the IFMap row tagger: default geometry, tag bit positions
// and the frame sequencer states.
package ifmap_pkg;

    localparam int IFMAP_WIDTH_DEF = 18;
    localparam int BUF_DEPTH_DEF   = 16;
    localparam int LEN_WIDTH_DEF   = 8;
    localparam int ROWS_WIDTH_DEF  = 8;

    localparam int SOR_BIT     = IFMAP_WIDTH_DEF - 1;
    localparam int EOR_BIT     = IFMAP_WIDTH_DEF - 2;
    localparam int PIXEL_WIDTH = IFMAP_WIDTH_DEF - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FIN    = 2'd2
    } state_t;

    // Tag positions for a non-default word width.
    function automatic int sor_bit(input int w);
        return w - 1;
    endfunction

    function automatic int eor_bit(input int w);
        return w - 2;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Credit tracker for a downstream buffer without a full flag: one credit spent per
// write, one returned per read, saturating at the buffer depth.
module credit_counter #(
    parameter int DEPTH = 16,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          consume,
    input  logic          ret,
    output logic [CW-1:0] count,
    output logic          zero
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (consume && !ret) begin
            count_next = count_reg - CW'(1);
        end else if (ret && !consume && (count_reg != FULL)) begin
            count_next = count_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= FULL;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);

    // A return with the buffer already empty means the two sides disagree.
    always @(posedge clk) begin
        if (rst && ret && !consume) begin
            assert (count_reg != FULL);
        end
        if (rst && consume) begin
            assert (count_reg != '0);
        end
    end

endmodule

// File: rtl/ifmap_row_tagger.sv
// Feeds the PE IFMap buffer: accepts a pixel stream, marks first/last pixel of each
// row and writes one tagged word per accepted pixel, throttled by buffer credits.
module ifmap_row_tagger
    import ifmap_pkg::*;
#(
    parameter int IFMAP_WIDTH = IFMAP_WIDTH_DEF,
    parameter int BUF_DEPTH   = BUF_DEPTH_DEF,
    parameter int LEN_WIDTH   = LEN_WIDTH_DEF,
    parameter int ROWS_WIDTH  = ROWS_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   row_len,
    input  logic [ROWS_WIDTH-1:0]  num_rows,
    input  logic                   s_valid,
    input  logic [IFMAP_WIDTH-3:0] s_data,
    output logic                   s_ready,
    output logic [IFMAP_WIDTH-1:0] ifmap_out,
    output logic                   ifmap_wen,
    input  logic                   ifmap_pop,
    output logic                   busy,
    output logic                   done
);

    localparam int SOR = sor_bit(IFMAP_WIDTH);
    localparam int EOR = eor_bit(IFMAP_WIDTH);
    localparam int PW  = IFMAP_WIDTH - 2;
    localparam int CW  = $clog2(BUF_DEPTH + 1);

    state_t state_reg;
    state_t state_next;

    logic [LEN_WIDTH-1:0]   len_reg;
    logic [LEN_WIDTH-1:0]   col_reg;
    logic [ROWS_WIDTH-1:0]  rows_reg;
    logic [ROWS_WIDTH-1:0]  row_reg;
    logic [IFMAP_WIDTH-1:0] out_reg;
    logic                   wen_reg;
    logic                   done_reg;

    logic [CW-1:0] credit_count;
    logic          credit_zero;
    logic          accept;
    logic          start_ok;
    logic          last_col;
    logic          last_row;

    assign accept   = s_valid && s_ready;
    assign start_ok = (state_reg == IDLE) && start;
    assign last_col = (col_reg == len_reg - LEN_WIDTH'(1));
    assign last_row = (row_reg == rows_reg - ROWS_WIDTH'(1));

    credit_counter #(
        .DEPTH (BUF_DEPTH)
    ) u_credits (
        .clk     (clk),
        .rst     (rst),
        .consume (accept),
        .ret     (ifmap_pop),
        .count   (credit_count),
        .zero    (credit_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    // An empty frame skips streaming but still reports completion.
                    state_next = ((row_len == '0) || (num_rows == '0)) ? FIN : STREAM;
                end
            end
            STREAM: begin
                if (accept && last_col && last_row) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state_reg == STREAM) && !credit_zero;
        busy    = (state_reg == STREAM) || (state_reg == FIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_reg  <= '0;
            rows_reg <= '0;
            col_reg  <= '0;
            row_reg  <= '0;
            out_reg  <= '0;
            wen_reg  <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            wen_reg  <= accept;
            // Lags FIN by one so done lands after the final write strobe.
            done_reg <= (state_reg == FIN);
            if (start_ok) begin
                len_reg  <= row_len;
                rows_reg <= num_rows;
                col_reg  <= '0;
                row_reg  <= '0;
            end else if (accept) begin
                out_reg[SOR]    <= (col_reg == '0);
                out_reg[EOR]    <= last_col;
                out_reg[PW-1:0] <= s_data;
                if (last_col) begin
                    col_reg <= '0;
                    row_reg <= row_reg + ROWS_WIDTH'(1);
                end else begin
                    col_reg <= col_reg + LEN_WIDTH'(1);
                end
            end
        end
    end

    assign ifmap_out = out_reg;
    assign ifmap_wen = wen_reg;
    assign done      = done_reg;

    always @(posedge clk) begin
        if (rst && accept) begin
            assert (credit_count != '0);
        end
    end

endmodule

// File: tb/tb_ifmap_row_tagger.sv
// Directed bench for ifmap_row_tagger with a scoreboard of expected tagged words
// and a model of the PE buffer that only reads when it holds data.
module tb_ifmap_row_tagger;

    localparam int W  = 18;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    row_len = '0;
    logic [7:0]    num_rows = '0;
    logic          s_valid = 1'b0;
    logic [PW-1:0] s_data = '0;
    logic          s_ready;
    logic [W-1:0]  ifmap_out;
    logic          ifmap_wen;
    logic          ifmap_pop = 1'b0;
    logic          busy;
    logic          done;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    int frame_writes = 0;
    int last_wr_cyc = 0;
    int start_cyc = 0;
    int m_col = 0;
    int m_len = 0;
    int vmode = 0;
    bit pop_en = 1'b0;
    int occ = 0;
    bit tog = 1'b0;
    bit acc = 1'b0;
    logic [W-1:0] q[$];
    logic [W-1:0] exp_word;

    ifmap_row_tagger dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .row_len   (row_len),
        .num_rows  (num_rows),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .ifmap_out (ifmap_out),
        .ifmap_wen (ifmap_wen),
        .ifmap_pop (ifmap_pop),
        .busy      (busy),
        .done      (done)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Source and PE-buffer model: new pixel after each accept, pops only when data is held.
    initial forever begin
        @(negedge clk);
        acc = rst && s_valid && s_ready;
        if (!rst) occ = 0;
        else occ = occ + (ifmap_wen ? 1 : 0) - (ifmap_pop ? 1 : 0);
        @(posedge clk);
        #1;
        if (acc) s_data = PW'($urandom);
        tog = ~tog;
        s_valid = (vmode == 1) || ((vmode == 2) && tog);
        ifmap_pop = rst && pop_en && (occ > 0);
    end

    // Scoreboard: expected word pushed on accept, compared on write strobe.
    always @(negedge clk) begin
        if (rst) begin
            if (ifmap_wen) begin
                chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    exp_word = q.pop_front();
                    chk("ifmap_out", 32'(ifmap_out), 32'(exp_word));
                end
                frame_writes++;
                last_wr_cyc = cyc;
                $display("write %0d: out=0x%05h tags=%b%b", frame_writes, ifmap_out,
                         ifmap_out[W-1], ifmap_out[W-2]);
            end
            if (s_valid && s_ready) begin
                q.push_back({m_col == 0, m_col == m_len - 1, s_data});
                if (m_col == m_len - 1) m_col = 0;
                else m_col++;
            end
        end
    end

    task automatic do_start(input int len, input int rows, input bit upd);
        @(posedge clk);
        #1;
        row_len = 8'(len);
        num_rows = 8'(rows);
        start = 1'b1;
        if (upd) begin
            m_len = len;
            m_col = 0;
            frame_writes = 0;
            start_cyc = cyc;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound, input bit after_write,
                             output int dcyc);
        bit seen;
        seen = 1'b0;
        dcyc = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            if (after_write) chk({tag, "_done_after_last_write"}, 32'(dcyc - last_wr_cyc), 32'd1);
            @(negedge clk);
            chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        int dcyc;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wen", 32'(ifmap_wen), 32'd0);
        chk("rst_out", 32'(ifmap_out), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Full credit pool: 16 accepts without pops, then reset mid-frame
        vmode = 1;
        pop_en = 1'b0;
        do_start(8, 4, 1'b1);
        repeat (25) @(negedge clk);
        chk("t1_writes", 32'(frame_writes), 32'd16);
        chk("t1_ready_low", 32'(s_ready), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        vmode = 0;
        rst = 1'b0;
        #1;
        chk("t1_abort_wen", 32'(ifmap_wen), 32'd0);
        chk("t1_abort_out", 32'(ifmap_out), 32'd0);
        chk("t1_abort_ready", 32'(s_ready), 32'd0);
        chk("t1_abort_busy", 32'(busy), 32'd0);
        chk("t1_abort_done", 32'(done), 32'd0);
        q.delete();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1_no_done_after_abort", 32'(done), 32'd0);

        // 4x2 frame with continuous pops
        vmode = 1;
        pop_en = 1'b1;
        do_start(4, 2, 1'b1);
        wait_done("t2", 100, 1'b1, dcyc);
        chk("t2_writes", 32'(frame_writes), 32'd8);

        // Credit exhaustion: 20-pixel row, no pops
        pop_en = 1'b0;
        repeat (20) @(negedge clk);
        do_start(20, 1, 1'b1);
        repeat (30) @(negedge clk);
        chk("t3_writes_stall", 32'(frame_writes), 32'd16);
        chk("t3_ready_low", 32'(s_ready), 32'd0);
        chk("t3_no_done", 32'(done), 32'd0);
        pop_en = 1'b1;
        wait_done("t3", 100, 1'b1, dcyc);
        chk("t3_writes", 32'(frame_writes), 32'd20);

        // Single-pixel rows carry both tags
        do_start(1, 3, 1'b1);
        wait_done("t4", 100, 1'b1, dcyc);
        chk("t4_writes", 32'(frame_writes), 32'd3);

        // Empty frame: no writes, done two cycles after start
        do_start(0, 5, 1'b1);
        wait_done("t5a", 20, 1'b0, dcyc);
        chk("t5a_done_latency", 32'(dcyc - start_cyc), 32'd2);
        chk("t5a_writes", 32'(frame_writes), 32'd0);

        // Start while busy is ignored
        do_start(3, 2, 1'b1);
        chk("t5b_busy", 32'(busy), 32'd1);
        do_start(1, 1, 1'b0);
        wait_done("t5b", 100, 1'b1, dcyc);
        chk("t5b_writes", 32'(frame_writes), 32'd6);

        // Accept and pop together at one credit, then gapped input
        pop_en = 1'b0;
        repeat (20) @(negedge clk);
        do_start(10, 4, 1'b1);
        repeat (25) @(negedge clk);
        chk("t6_ready_low", 32'(s_ready), 32'd0);
        pop_en = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t6_ready_at_one_credit", 32'(s_ready), 32'd1);
        end
        vmode = 2;
        wait_done("t6", 400, 1'b1, dcyc);
        chk("t6_writes", 32'(frame_writes), 32'd40);
        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
